mem_responder: RTL and testbench

- Synthesizable main-memory responder for the cache/arbiter memory protocol (mem_req_* / mem_req_data_* / mem_resp_*).
- Sits where the external memory model sits, below the arbiter. Gives the icache/dcache subsystem a cycle-accurate target for RTL simulation and FPGA bring-up.
- Accepts one line request at a time:
  - A write consumes DATA_CYCLES masked data beats.
  - A read returns DATA_CYCLES tagged beats after a fixed latency.

---
 rtl/mem_responder.sv | 143 ++++++++++++++
 tb/tb_mem_responder.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_responder.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mem_responder : line-oriented main-memory target (masked line writes,
//                 tagged fixed-latency line reads)            Rev 1.0
// ---------------------------------------------------------------------------
module mem_responder #(
  parameter int ADDR_BITS    = 28,
  parameter int DATA_BITS    = 128,
  parameter int TAG_BITS     = 5,
  parameter int DATA_CYCLES  = 4,
  parameter int DEPTH_LOG2   = 10,
  parameter int READ_LATENCY = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   mem_req_valid,
  output logic                   mem_req_ready,
  input  logic                   mem_req_rw,
  input  logic [ADDR_BITS-1:0]   mem_req_addr,
  input  logic [TAG_BITS-1:0]    mem_req_tag,
  input  logic                   mem_req_data_valid,
  output logic                   mem_req_data_ready,
  input  logic [DATA_BITS-1:0]   mem_req_data_bits,
  input  logic [DATA_BITS/8-1:0] mem_req_data_mask,
  output logic                   mem_resp_valid,
  output logic [DATA_BITS-1:0]   mem_resp_data,
  output logic [TAG_BITS-1:0]    mem_resp_tag
);

  localparam int                    BEAT_BITS  = $clog2(DATA_CYCLES);
  localparam int                    MASK_BITS  = DATA_BITS / 8;
  localparam logic [BEAT_BITS-1:0]  LAST_BEAT  = BEAT_BITS'(DATA_CYCLES - 1);
  localparam logic [BEAT_BITS-1:0]  BEAT_ONE   = BEAT_BITS'(1);
  localparam logic [DEPTH_LOG2-1:0] ALIGN_MASK = ~DEPTH_LOG2'(DATA_CYCLES - 1);
  localparam logic [3:0]            LAT_INIT   = 4'(READ_LATENCY);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WDATA = 2'd1,
    RLAT  = 2'd2,
    RESP  = 2'd3
  } state_e;

  state_e                state_q, state_d;
  logic [DEPTH_LOG2-1:0] base_q, base_d;
  logic [TAG_BITS-1:0]   tag_q, tag_d;
  logic [BEAT_BITS-1:0]  beat_q, beat_d;
  logic [3:0]            lat_q, lat_d;
  logic [DATA_BITS-1:0]  resp_data_q;
  logic [DATA_BITS-1:0]  mem_q [2**DEPTH_LOG2];

  logic                  wr_en;
  logic [DEPTH_LOG2-1:0] wr_idx;
  logic [DEPTH_LOG2-1:0] rd_idx;
  logic                  unused_addr_hi;

  // Upper address bits alias onto the same storage.
  assign unused_addr_hi = ^mem_req_addr[ADDR_BITS-1:DEPTH_LOG2];

  assign wr_idx = base_q + DEPTH_LOG2'(beat_q);
  // Read data is fetched one edge early (from next-state) so each beat is
  // registered exactly while its RESP cycle is current.
  assign rd_idx = base_d + DEPTH_LOG2'(beat_d);

  always_comb begin
    state_d            = state_q;
    base_d             = base_q;
    tag_d              = tag_q;
    beat_d             = beat_q;
    lat_d              = lat_q;
    mem_req_ready      = 1'b0;
    mem_req_data_ready = 1'b0;
    wr_en              = 1'b0;
    case (state_q)
      IDLE: begin
        mem_req_ready = 1'b1;
        if (mem_req_valid) begin
          base_d = mem_req_addr[DEPTH_LOG2-1:0] & ALIGN_MASK;
          tag_d  = mem_req_tag;
          beat_d = '0;
          if (mem_req_rw) begin
            state_d = WDATA;
          end else if (READ_LATENCY == 0) begin
            state_d = RESP;
          end else begin
            state_d = RLAT;
            lat_d   = LAT_INIT;
          end
        end
      end
      WDATA: begin
        mem_req_data_ready = 1'b1;
        if (mem_req_data_valid) begin
          wr_en  = 1'b1;
          beat_d = beat_q + BEAT_ONE;
          if (beat_q == LAST_BEAT) state_d = IDLE;
        end
      end
      RLAT: begin
        lat_d = lat_q - 4'd1;
        if (lat_q == 4'd1) state_d = RESP;
      end
      RESP: begin
        beat_d = beat_q + BEAT_ONE;
        if (beat_q == LAST_BEAT) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      base_q      <= '0;
      tag_q       <= '0;
      beat_q      <= '0;
      lat_q       <= '0;
      resp_data_q <= '0;
    end else begin
      state_q     <= state_d;
      base_q      <= base_d;
      tag_q       <= tag_d;
      beat_q      <= beat_d;
      lat_q       <= lat_d;
      resp_data_q <= (state_d == RESP) ? mem_q[rd_idx] : '0;
    end
  end

  // Storage has no reset: contents survive a reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int b = 0; b < MASK_BITS; b++) begin
        if (mem_req_data_mask[b]) mem_q[wr_idx][b*8 +: 8] <= mem_req_data_bits[b*8 +: 8];
      end
    end
  end

  assign mem_resp_valid = (state_q == RESP);
  assign mem_resp_data  = resp_data_q;
  assign mem_resp_tag   = tag_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_responder.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_mem_responder : directed checks of mem_responder (READ_LATENCY 2 and 0)
//                                                             Rev 1.0
// ---------------------------------------------------------------------------
module tb_mem_responder;

  logic         clk = 1'b0;
  logic         rst;
  logic         sel;          // 0: latency-2 instance, 1: latency-0 instance
  logic         req_valid, req_rw, data_valid;
  logic [27:0]  req_addr;
  logic [4:0]   req_tag;
  logic [127:0] data_bits;
  logic [15:0]  data_mask;

  logic         rdy2, drdy2, rv2, rdy0, drdy0, rv0;
  logic [127:0] rd2, rd0;
  logic [4:0]   rt2, rt0;

  logic         w_req_ready, w_data_ready, w_resp_valid;
  logic [127:0] w_resp_data;
  logic [4:0]   w_resp_tag;

  logic [127:0] wd [4];
  logic [15:0]  wm [4];
  logic [127:0] rb [4];
  int           n_chk  = 0;
  int           n_pass = 0;
  int           resp_cnt = 0;
  int           c0;

  always #5 clk = ~clk;

  mem_responder #(.READ_LATENCY(2)) u_dut2 (
    .clk(clk), .reset(rst),
    .mem_req_valid(req_valid && !sel), .mem_req_ready(rdy2),
    .mem_req_rw(req_rw), .mem_req_addr(req_addr), .mem_req_tag(req_tag),
    .mem_req_data_valid(data_valid && !sel), .mem_req_data_ready(drdy2),
    .mem_req_data_bits(data_bits), .mem_req_data_mask(data_mask),
    .mem_resp_valid(rv2), .mem_resp_data(rd2), .mem_resp_tag(rt2)
  );

  mem_responder #(.READ_LATENCY(0)) u_dut0 (
    .clk(clk), .reset(rst),
    .mem_req_valid(req_valid && sel), .mem_req_ready(rdy0),
    .mem_req_rw(req_rw), .mem_req_addr(req_addr), .mem_req_tag(req_tag),
    .mem_req_data_valid(data_valid && sel), .mem_req_data_ready(drdy0),
    .mem_req_data_bits(data_bits), .mem_req_data_mask(data_mask),
    .mem_resp_valid(rv0), .mem_resp_data(rd0), .mem_resp_tag(rt0)
  );

  assign w_req_ready  = sel ? rdy0  : rdy2;
  assign w_data_ready = sel ? drdy0 : drdy2;
  assign w_resp_valid = sel ? rv0   : rv2;
  assign w_resp_data  = sel ? rd0   : rd2;
  assign w_resp_tag   = sel ? rt0   : rt2;

  always @(negedge clk) if (w_resp_valid) resp_cnt++;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Line write using wd/wm, with 'gap' idle cycles before every beat.
  task automatic do_write(input logic [27:0] a, input int gap);
    int n;
    @(negedge clk);
    req_valid = 1'b1; req_rw = 1'b1; req_addr = a; req_tag = '0;
    n = 0;
    while (!w_req_ready && n < 100) begin @(negedge clk); n++; end
    chk("wr_req_ready", 128'(w_req_ready), 128'd1);
    @(negedge clk);
    req_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      repeat (gap) @(negedge clk);
      data_valid = 1'b1; data_bits = wd[k]; data_mask = wm[k];
      chk("wr_data_ready", 128'(w_data_ready), 128'd1);
      @(negedge clk);
      data_valid = 1'b0;
    end
  endtask

  // Line read into rb; checks per-cycle valid timing and tag. With 'hold'
  // the request stays asserted (with a different addr/tag) until IDLE.
  task automatic do_read(input logic [27:0] a, input logic [4:0] t, input bit hold);
    int n;
    int rl;
    rl = sel ? 0 : 2;
    @(negedge clk);
    req_valid = 1'b1; req_rw = 1'b0; req_addr = a; req_tag = t;
    n = 0;
    while (!w_req_ready && n < 100) begin @(negedge clk); n++; end
    chk("rd_req_ready", 128'(w_req_ready), 128'd1);
    @(negedge clk);
    if (hold) begin req_addr = a ^ 28'h80; req_tag = ~t; end
    else req_valid = 1'b0;
    for (int i = 0; i < rl + 4; i++) begin
      if (i >= rl) begin
        chk("rd_valid", 128'(w_resp_valid), 128'd1);
        chk("rd_tag", 128'(w_resp_tag), 128'(t));
        rb[i-rl] = w_resp_data;
      end else begin
        chk("rd_latency", 128'(w_resp_valid), 128'd0);
      end
      if (hold) chk("hold_ready", 128'(w_req_ready), 128'd0);
      @(negedge clk);
    end
    chk("rd_end_valid", 128'(w_resp_valid), 128'd0);
    if (hold) begin
      chk("hold_idle_ready", 128'(w_req_ready), 128'd1);
      req_valid = 1'b0;
    end
  endtask

  task automatic fill(input logic [7:0] b0, input logic [7:0] b1,
                      input logic [7:0] b2, input logic [7:0] b3, input logic [15:0] m);
    wd[0] = {16{b0}}; wd[1] = {16{b1}}; wd[2] = {16{b2}}; wd[3] = {16{b3}};
    for (int k = 0; k < 4; k++) wm[k] = m;
  endtask

  task automatic chk_line(input string tag, input logic [7:0] b0, input logic [7:0] b1,
                          input logic [7:0] b2, input logic [7:0] b3);
    chk(tag, rb[0], {16{b0}});
    chk(tag, rb[1], {16{b1}});
    chk(tag, rb[2], {16{b2}});
    chk(tag, rb[3], {16{b3}});
  endtask

  initial begin
    rst = 1'b1; sel = 1'b0;
    req_valid = 1'b0; req_rw = 1'b0; req_addr = '0; req_tag = '0;
    data_valid = 1'b0; data_bits = '0; data_mask = '0;
    repeat (3) @(negedge clk);
    chk("rst_req_ready", 128'(w_req_ready), 128'd1);
    chk("rst_data_ready", 128'(w_data_ready), 128'd0);
    chk("rst_resp_valid", 128'(w_resp_valid), 128'd0);
    chk("rst_resp_tag", 128'(w_resp_tag), 128'd0);
    chk("rst_resp_data", w_resp_data, 128'd0);
    rst = 1'b0;

    // full-line write then read
    fill(8'h11, 8'h22, 8'h33, 8'h44, 16'hFFFF);
    c0 = resp_cnt;
    do_write(28'h40, 0);
    chk("wr1_no_resp", 128'(resp_cnt), 128'(c0));
    do_read(28'h40, 5'd5, 1'b0);
    chk_line("full_rd", 8'h11, 8'h22, 8'h33, 8'h44);

    // single-byte mask on beat 0 only
    fill(8'hFF, 8'hFF, 8'hFF, 8'hFF, 16'h0000);
    wd[0] = 128'hAA; wm[0] = 16'h0001;
    do_write(28'h40, 0);
    do_read(28'h40, 5'd9, 1'b0);
    chk("mask_b0", rb[0], {{15{8'h11}}, 8'hAA});
    chk("mask_b1", rb[1], {16{8'h22}});
    chk("mask_b2", rb[2], {16{8'h33}});
    chk("mask_b3", rb[3], {16{8'h44}});

    // gapped write data, then read with request held and changed
    fill(8'hC1, 8'hC2, 8'hC3, 8'hC4, 16'hFFFF);
    c0 = resp_cnt;
    do_write(28'h80, 3);
    chk("gap_no_resp", 128'(resp_cnt), 128'(c0));
    do_read(28'h80, 5'd2, 1'b1);
    chk_line("hold_rd", 8'hC1, 8'hC2, 8'hC3, 8'hC4);

    // unaligned address reads the enclosing line
    do_read(28'h43, 5'd1, 1'b0);
    chk("align_b0", rb[0], {{15{8'h11}}, 8'hAA});
    chk("align_b3", rb[3], {16{8'h44}});

    // upper address bits alias
    fill(8'h55, 8'h66, 8'h77, 8'h88, 16'hFFFF);
    do_write(28'h440, 0);
    do_read(28'h40, 5'd4, 1'b0);
    chk_line("alias_rd", 8'h55, 8'h66, 8'h77, 8'h88);

    // reset during beat 1 of a response
    @(negedge clk);
    req_valid = 1'b1; req_rw = 1'b0; req_addr = 28'h40; req_tag = 5'd7;
    @(negedge clk);
    req_valid = 1'b0;
    begin
      int n;
      n = 0;
      while (!w_resp_valid && n < 20) begin @(negedge clk); n++; end
    end
    chk("rst_mid_beat0", 128'(w_resp_valid), 128'd1);
    @(negedge clk);
    chk("rst_mid_beat1", w_resp_data, {16{8'h66}});
    #1 rst = 1'b1;
    #1;
    chk("rst_mid_valid", 128'(w_resp_valid), 128'd0);
    chk("rst_mid_ready", 128'(w_req_ready), 128'd1);
    @(negedge clk);
    rst = 1'b0;
    do_read(28'h40, 5'd7, 1'b0);
    chk_line("post_rst_rd", 8'h55, 8'h66, 8'h77, 8'h88);

    // zero-latency instance, stray write data while idle
    sel = 1'b1;
    fill(8'hD1, 8'hD2, 8'hD3, 8'hD4, 16'hFFFF);
    do_write(28'h10, 0);
    @(negedge clk);
    data_valid = 1'b1; data_bits = '1; data_mask = 16'hFFFF;
    for (int i = 0; i < 3; i++) begin
      chk("stray_data_ready", 128'(w_data_ready), 128'd0);
      @(negedge clk);
    end
    data_valid = 1'b0;
    do_read(28'h10, 5'd3, 1'b0);
    chk_line("lat0_rd", 8'hD1, 8'hD2, 8'hD3, 8'hD4);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
